// File: rtl/dmem_wbuf.sv
// Purpose: Memory-stage data memory with a local word RAM and a posted-write FIFO for the 0xFFFF_xxxx I/O window.
// Latency: loads are combinational; a RAM store is visible next cycle; an I/O store reaches the bus head one cycle later.
// Backpressure: the core never stalls, so an I/O store that finds no free slot is dropped and counted (saturating at 255).
//
// Ports:
//   clk, reset (async, active-low)     - clock and reset
//   MemWriteM, ALUOutM, WriteDataM     - store strobe, byte address and store data from the Memory stage
//   ReadDataM                          - combinational load data (RAM word, I/O status word, or 0)
//   io_valid, io_addr, io_data         - FIFO head presented to the peripheral bus
//   io_ready                           - peripheral accepts the head this edge
//   fifo_full                          - FIFO holds FIFO_DEPTH entries
module dmem_wbuf #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        io_valid,
    output logic [13:0] io_addr,
    output logic [31:0] io_data,
    input  logic        io_ready,
    output logic        fifo_full
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem    [RAM_WORDS];
    logic [13:0]   q_addr [FIFO_DEPTH];
    logic [31:0]   q_data [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [7:0]    ovf_cnt;

    logic          is_io;
    logic          is_status;
    logic          is_clr;
    logic [AW-1:0] ram_idx;
    logic          ram_we;
    logic          clr_st;
    logic          enq_req;
    logic          deq;
    logic          slot_free;
    logic          enq;
    logic          drop;
    logic [31:0]   status;

    // Address decode: the top halfword selects the I/O window, upper RAM bits alias.
    assign is_io     = (ALUOutM[31:16] == 16'hFFFF);
    assign is_status = is_io && (ALUOutM[15:0] == 16'h0000);
    assign is_clr    = is_io && (ALUOutM[15:0] == 16'hFFFC);
    assign ram_idx   = ALUOutM[AW+1:2];

    assign ram_we    = MemWriteM && !is_io;
    assign clr_st    = MemWriteM && is_clr;
    assign enq_req   = MemWriteM && is_io && !is_clr;

    // A dequeue on the same edge frees a slot, so a full FIFO can still accept a store while draining.
    assign deq       = io_valid && io_ready;
    assign slot_free = (count != CW'(FIFO_DEPTH)) || deq;
    assign enq       = enq_req && slot_free;
    assign drop      = enq_req && !slot_free;

    assign io_valid  = (count != '0);
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign io_addr   = q_addr[rd_ptr];
    assign io_data   = q_data[rd_ptr];

    // Local RAM: not reset, asynchronous read, synchronous write.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= WriteDataM;
        end
    end

    // FIFO storage needs no reset: validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= ALUOutM[15:2];
            q_data[wr_ptr] <= WriteDataM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf_cnt <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (enq && !deq) begin
                count <= count + 1'b1;
            end else if (deq && !enq) begin
                count <= count - 1'b1;
            end
            if (clr_st) begin
                ovf_cnt <= '0;
            end else if (drop && (ovf_cnt != 8'hFF)) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        status        = '0;
        status[3:0]   = 4'(count);
        status[4]     = fifo_full;
        status[5]     = !io_valid;
        status[15:8]  = ovf_cnt;
    end

    always_comb begin
        ReadDataM = '0;
        if (!is_io) begin
            ReadDataM = mem[ram_idx];
        end else if (is_status) begin
            ReadDataM = status;
        end
    end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Purpose: self-checking bench for dmem_wbuf: RAM vector table plus posted-write, overflow and reset sequences.
// Latency: inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
// Backpressure: a queue holds the expected FIFO contents; the head is compared every cycle and popped on dequeue.
module tb_dmem_wbuf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUOutM = 32'hFFFF_0000;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        io_valid;
    logic [13:0] io_addr;
    logic [31:0] io_data;
    logic        io_ready = 1'b0;
    logic        fifo_full;

    dmem_wbuf #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .io_valid   (io_valid),
        .io_addr    (io_addr),
        .io_data    (io_data),
        .io_ready   (io_ready),
        .fifo_full  (fifo_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          ck;
        logic [31:0] exp;
    } vec_t;

    ent_t sb[$];
    int   m_ovf  = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive on the falling edge, check, then update the reference queue at the rising edge.
    task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy,
                       input bit ck, input logic [31:0] exp, input string nm);
        bit io, clr, enq_req, deq, slot;
        ent_t e;
        @(negedge clk);
        MemWriteM  = we;
        ALUOutM    = a;
        WriteDataM = wd;
        io_ready   = rdy;
        #1;
        chk({nm, "_valid"}, io_valid, (sb.size() != 0));
        chk({nm, "_full"}, fifo_full, (sb.size() == 4));
        if (sb.size() != 0) begin
            chk({nm, "_head_addr"}, io_addr, sb[0].a);
            chk({nm, "_head_data"}, io_data, sb[0].d);
        end
        if (ck) chk({nm, "_rd"}, ReadDataM, exp);
        io      = (a[31:16] == 16'hFFFF);
        clr     = we && io && (a[15:0] == 16'hFFFC);
        enq_req = we && io && !clr;
        deq     = rdy && (sb.size() != 0);
        slot    = (sb.size() < 4) || deq;
        @(posedge clk);
        if (deq) void'(sb.pop_front());
        if (clr) m_ovf = 0;
        if (enq_req) begin
            if (slot) begin
                e.a = a[15:2];
                e.d = wd;
                sb.push_back(e);
            end else if (m_ovf < 255) begin
                m_ovf++;
            end
        end
    endtask

    localparam logic [31:0] STAT = 32'hFFFF_0000;
    localparam logic [31:0] CLR  = 32'hFFFF_FFFC;

    initial begin
        vec_t        vt[10];
        logic [31:0] drain_exp[4];

        vt[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vt[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[2] = '{1'b0, 32'h0000_0110, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[3] = '{1'b1, 32'h0000_0024, 32'h1234_5678, 1'b0, 32'h0};
        vt[4] = '{1'b0, 32'h0000_0024, 32'h0,         1'b1, 32'h1234_5678};
        vt[5] = '{1'b0, 32'h0000_0027, 32'h0,         1'b1, 32'h1234_5678};
        vt[6] = '{1'b0, STAT,          32'h0,         1'b1, 32'h0000_0020};
        vt[7] = '{1'b0, 32'hFFFF_0008, 32'h0,         1'b1, 32'h0};
        vt[8] = '{1'b1, 32'h1000_0010, 32'hCAFE_F00D, 1'b0, 32'h0};
        vt[9] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hCAFE_F00D};

        // Reset state
        #12;
        chk("rst_valid", io_valid, 1'b0);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_status", ReadDataM, 32'h20);
        @(negedge clk);
        reset = 1'b1;

        // RAM path and decode table
        foreach (vt[i]) cyc(vt[i].we, vt[i].addr, vt[i].wd, 1'b0, vt[i].ck, vt[i].exp, "ram");

        // Posted write, held head, single-cycle handshake
        cyc(1'b1, 32'hFFFF_0040, 32'h11, 1'b0, 1'b0, 32'h0, "pw_st");
        #2;
        chk("pw_io_addr", io_addr, 14'h010);
        chk("pw_io_data", io_data, 32'h11);
        cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'h1, "pw_stat");
        for (int i = 0; i < 3; i++) cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'h1, "pw_hold");
        cyc(1'b0, STAT, 32'h0, 1'b1, 1'b1, 32'h1, "pw_deq");
        cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'h20, "pw_empty");

        // Fill to full, then drain on consecutive cycles
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hFFFF_0100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0, 32'h0, "of_st");
        cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'h14, "of_stat");
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("drain_valid", io_valid, 1'b1);
            chk("drain_data", io_data, 32'hA0 + 32'(i));
            cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "drain");
        end
        cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'h20, "drain_empty");

        // Overflow drops, counter clear, simultaneous enqueue/dequeue at full
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hFFFF_0200 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0, 32'h0, "ov_st");
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hFFFF_0280, 32'hD0 + 32'(i), 1'b0, 1'b0, 32'h0, "ov_drop");
        cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'h0314, "ov_stat3");
        cyc(1'b1, CLR, 32'h0, 1'b0, 1'b0, 32'h0, "ov_clr");
        cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'h0014, "ov_cleared");
        cyc(1'b1, 32'hFFFF_0300, 32'hB0, 1'b1, 1'b0, 32'h0, "sim_enq_deq");
        cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'h0014, "sim_stat");
        drain_exp = '{32'hC1, 32'hC2, 32'hC3, 32'hB0};
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("sim_drain_data", io_data, drain_exp[i]);
            cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "sim_drain");
        end
        cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'h20, "sim_empty");

        // Overflow counter saturation
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hFFFF_0400 + 32'(4 * i), 32'hE0 + 32'(i), 1'b0, 1'b0, 32'h0, "sat_st");
        for (int i = 0; i < 300; i++) cyc(1'b1, 32'hFFFF_0480, 32'(i), 1'b0, 1'b0, 32'h0, "sat_drop");
        cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'hFF14, "sat_stat");
        cyc(1'b1, CLR, 32'h0, 1'b0, 1'b0, 32'h0, "sat_clr");
        cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'h0014, "sat_cleared");

        // Reset between edges with two entries pending and a handshake in flight
        for (int i = 0; i < 2; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "pre_rst");
        @(negedge clk);
        MemWriteM = 1'b0;
        ALUOutM   = STAT;
        io_ready  = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", io_valid, 1'b0);
        chk("arst_full", fifo_full, 1'b0);
        chk("arst_status", ReadDataM, 32'h20);
        sb.delete();
        m_ovf = 0;
        @(negedge clk);
        #1;
        chk("arst_hold_valid", io_valid, 1'b0);
        chk("arst_hold_status", ReadDataM, 32'h20);
        reset = 1'b1;

        // Normal operation after release; RAM contents survive reset
        cyc(1'b0, 32'h0000_0024, 32'h0, 1'b0, 1'b1, 32'h1234_5678, "post_rst_ram");
        cyc(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, "post_rst_ram2");
        cyc(1'b1, 32'hFFFF_0044, 32'h55, 1'b0, 1'b0, 32'h0, "post_rst_st");
        cyc(1'b0, STAT, 32'h0, 1'b0, 1'b1, 32'h1, "post_rst_stat");
        #2;
        chk("post_rst_addr", io_addr, 14'h011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
